pipeline_skid_buffer: RTL and testbench
=======================================

Name: pipeline_skid_buffer

Overview:
- Receiving end of a registered pipeline stage: accepts WIDTH-bit words from an upstream producer and delivers them to a downstream consumer over a valid/ready handshake.
- Absorbs one extra word when the consumer stalls, so upstream ready is fully registered and no data is lost or duplicated.
- Sits between any pipeline register stage and a consumer that can apply backpressure. Includes a saturating stall counter for debug.

Parameters:
- WIDTH, 4, data width in bits.
- PIPELINE_ENABLE, 1, 1 = registered skid buffer; 0 = combinational pass-through with no storage.
- STALL_CNT_W, 8, width of the saturating stall counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  upstream data.
- in_valid  input  1  upstream word present.
- in_ready  output  1  block can accept a word this cycle. Registered when PIPELINE_ENABLE=1.
- out_data  output  WIDTH  downstream data, driven from the main register.
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  consumer accepts a word this cycle.
- stall_cnt  output  STALL_CNT_W  cycles with out_valid=1 and out_ready=0; saturates at all-ones.

Behaviour:
- Reset: synchronous, active-high, applied on the clk edge with rst=1. rst overrides all other inputs.
- Values after the reset edge: state=EMPTY, main and skid registers=0, out_data=0, out_valid=0, in_ready=1, stall_cnt=0.
- Reset mid-transfer discards any held words; no handshake completes on a reset edge.
- Handshake definitions:
  - Upstream transfer when in_valid & in_ready at an edge.
  - Downstream transfer when out_valid & out_ready at an edge.
  - out_data and out_valid must be held stable while out_valid=1 and out_ready=0.
- PIPELINE_ENABLE=1 state machine:
  - EMPTY (out_valid=0): upstream transfer -> main<=in_data, go to BUSY.
  - BUSY (out_valid=1, skid empty):
    - in xfer & out_ready -> main<=in_data, stay BUSY (full throughput).
    - in xfer & !out_ready -> skid<=in_data, go to FULL.
    - no in xfer & out_ready -> go to EMPTY.
    - otherwise hold.
  - FULL (out_valid=1, skid holds the next word):
    - out_ready -> main<=skid, go to BUSY.
    - otherwise hold.
    - in_ready=0, so no upstream transfer occurs in FULL.
- in_ready is registered as (next_state != FULL); it drops on the same edge the skid is loaded.
- Latency (PIPELINE_ENABLE=1): a word accepted at edge N is visible on out_data/out_valid after edge N. Word order is strictly preserved.
- Throughput: 1 word/cycle sustained while out_ready=1.
- Boundary conditions:
  - in_valid with in_ready=0 is ignored; the producer must hold the word.
  - out_ready with out_valid=0 has no effect.
  - Simultaneous in and out transfers in BUSY update main only; the skid is untouched.
- PIPELINE_ENABLE=0:
  - out_data=in_data, out_valid=in_valid, in_ready=out_ready, all combinational; no storage; zero latency.
  - Reset affects only stall_cnt.
- stall_cnt:
  - Increments on each edge where out_valid=1 and out_ready=0.
  - Holds at 2^STALL_CNT_W-1 once saturated.
  - Cleared only by rst.

Test Plan:
1. Reset and idle: rst=1 for 2 edges, then rst=0 with in_valid=0 -> out_valid=0, out_data=0, in_ready=1, stall_cnt=0.
2. Streaming: out_ready=1, in_data=1,2,3,...,10 on consecutive cycles with in_valid=1 -> out_data=1..10 one cycle later each, out_valid=1 throughout, in_ready=1 always, stall_cnt=0.
3. Skid fill, stall 3 cycles, release:
   - Send 0x5 then 0x6 with out_ready=0 -> out_data=0x5, in_ready=0 after the second edge, 0x6 not visible.
   - Hold 3 cycles -> stall_cnt=4.
   - Set out_ready=1 -> 0x5 then 0x6 delivered in order, in_ready returns to 1.
4. Reset in FULL: fill with 0xA and 0xB, assert rst for one edge -> out_valid=0, in_ready=1, out_data=0. With out_ready=1 afterwards, neither 0xA nor 0xB ever appears.
5. Saturation: STALL_CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15 and held.
6. Pass-through (PIPELINE_ENABLE=0): 100 random in_data/in_valid/out_ready values, each checked 1 time unit after change -> out_data==in_data, out_valid==in_valid, in_ready==out_ready.

Source files
------------

// File: rtl/pipeline_skid_buffer.sv
// Receiving end of a pipeline stage: a two-entry skid buffer that keeps upstream ready registered.
// With PIPELINE_ENABLE=0 it degenerates to a combinational pass-through; a debug stall counter remains.
module pipeline_skid_buffer #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned PIPELINE_ENABLE = 1,
  parameter int unsigned STALL_CNT_W     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {StEmpty, StBusy, StFull} state_e;

  if (PIPELINE_ENABLE != 0) begin : g_skid
    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready_q;
    logic             in_xfer;

    assign in_xfer = in_valid && in_ready_q;

    always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      unique case (state_q)
        StEmpty: begin
          if (in_xfer) begin
            main_d  = in_data;
            state_d = StBusy;
          end
        end
        StBusy: begin
          if (in_xfer && out_ready) begin
            main_d = in_data;
          end else if (in_xfer) begin
            skid_d  = in_data;
            state_d = StFull;
          end else if (out_ready) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (out_ready) begin
            main_d  = skid_q;
            state_d = StBusy;
          end
        end
        default: state_d = StEmpty;
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q    <= StEmpty;
        main_q     <= '0;
        skid_q     <= '0;
        in_ready_q <= 1'b1;
      end else begin
        state_q    <= state_d;
        main_q     <= main_d;
        skid_q     <= skid_d;
        // Ready drops on the same edge the skid is loaded.
        in_ready_q <= (state_d != StFull);
      end
    end

    assign out_valid = (state_q != StEmpty);
    assign out_data  = main_q;
    assign in_ready  = in_ready_q;
  end else begin : g_pass
    assign out_valid = in_valid;
    assign out_data  = in_data;
    assign in_ready  = out_ready;
  end

  logic [STALL_CNT_W-1:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_skid_buffer.sv
// Self-checking bench: a two-deep reference queue predicts outputs of the registered buffer,
// plus a combinational check of the pass-through build.
module tb_pipeline_skid_buffer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] stall_cnt;

  logic [3:0] pt_in_data = '0;
  logic       pt_in_valid = 1'b0;
  logic       pt_in_ready;
  logic [3:0] pt_out_data;
  logic       pt_out_valid;
  logic       pt_out_ready = 1'b0;
  logic [7:0] pt_stall_cnt;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  logic [3:0] exp_q[$];
  int         stall_exp = 0;

  always #5 clk = ~clk;

  pipeline_skid_buffer #(
    .WIDTH(4), .PIPELINE_ENABLE(1), .STALL_CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .stall_cnt(stall_cnt)
  );

  pipeline_skid_buffer #(
    .WIDTH(4), .PIPELINE_ENABLE(0), .STALL_CNT_W(8)
  ) dut_pt (
    .clk(clk), .rst(rst), .in_data(pt_in_data), .in_valid(pt_in_valid),
    .in_ready(pt_in_ready), .out_data(pt_out_data), .out_valid(pt_out_valid),
    .out_ready(pt_out_ready), .stall_cnt(pt_stall_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor pops/compares, then the predictor applies the transfers of the coming edge.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("out_valid", {31'b0, out_valid}, {31'b0, (exp_q.size() > 0)});
      if (exp_q.size() > 0) chk("out_data", {28'b0, out_data}, {28'b0, exp_q[0]});
      chk("in_ready", {31'b0, in_ready}, {31'b0, (exp_q.size() < 2)});
      chk("stall_cnt", {28'b0, stall_cnt}, stall_exp);
    end
    if (rst) begin
      exp_q.delete();
      stall_exp = 0;
    end else begin
      bit in_x;
      in_x = in_valid && (exp_q.size() < 2);
      if (exp_q.size() > 0 && !out_ready && stall_exp < 15) stall_exp++;
      if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
      if (in_x) exp_q.push_back(in_data);
    end
  end

  task automatic drive(input logic v, input logic [3:0] d, input logic r);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Reset and idle
    do_reset();
    @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_data", {28'b0, out_data}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_stall_cnt", {28'b0, stall_cnt}, 32'd0);

    // Streaming at full throughput
    for (int i = 1; i <= 10; i++) drive(1'b1, 4'(i), 1'b1);
    drive(1'b0, 4'h0, 1'b1);
    drive(1'b0, 4'h0, 1'b1);

    // Skid fill, stall, release
    do_reset();
    drive(1'b1, 4'h5, 1'b0);
    drive(1'b1, 4'h6, 1'b0);
    drive(1'b0, 4'h0, 1'b0);
    @(negedge clk);
    chk("full_out_data", {28'b0, out_data}, 32'h5);
    chk("full_in_ready", {31'b0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) drive(1'b0, 4'h0, 1'b0);
    @(negedge clk);
    chk("stall_after_hold", {28'b0, stall_cnt}, 32'd4);
    drive(1'b0, 4'h0, 1'b1);
    drive(1'b0, 4'h0, 1'b1);
    drive(1'b0, 4'h0, 1'b1);
    @(negedge clk);
    chk("drained_in_ready", {31'b0, in_ready}, 32'd1);

    // Reset while FULL discards both words
    do_reset();
    drive(1'b1, 4'hA, 1'b0);
    drive(1'b1, 4'hB, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("rst_full_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_full_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_full_out_data", {28'b0, out_data}, 32'd0);
    for (int i = 0; i < 4; i++) drive(1'b0, 4'h0, 1'b1);

    // Stall counter saturation
    do_reset();
    drive(1'b1, 4'h3, 1'b0);
    for (int i = 0; i < 20; i++) drive(1'b0, 4'h0, 1'b0);
    @(negedge clk);
    chk("stall_saturated", {28'b0, stall_cnt}, 32'd15);
    drive(1'b0, 4'h0, 1'b0);
    @(negedge clk);
    chk("stall_held", {28'b0, stall_cnt}, 32'd15);

    // Random traffic against the reference queue
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 3) != 0 || i[5]));
    end
    for (int i = 0; i < 4; i++) drive(1'b0, 4'h0, 1'b1);

    // Pass-through build
    for (int i = 0; i < 100; i++) begin
      pt_in_data   = 4'($urandom);
      pt_in_valid  = 1'($urandom);
      pt_out_ready = 1'($urandom);
      #1;
      chk("pt_out_data", {28'b0, pt_out_data}, {28'b0, pt_in_data});
      chk("pt_out_valid", {31'b0, pt_out_valid}, {31'b0, pt_in_valid});
      chk("pt_in_ready", {31'b0, pt_in_ready}, {31'b0, pt_out_ready});
    end

    @(posedge clk);
    #1;
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
